bounce_sprite_engine: RTL and testbench
=======================================

# bounce_sprite_engine

Parametrised sprite mover for the VGA exercises. It steps a single-pixel sprite across a configurable screen on a programmable tick. Before each step it probes an external obstacle RAM and the screen borders, and bounces off whatever it would hit. It sits between the obstacle `image_ram` (read side) and the frame-buffer pixel writer, and owns its own control FSM. No external controller is needed.

## Interface
- `X_W`, 8: x coordinate width
- `Y_W`, 7: y coordinate width
- `X_MAX`, 159: last legal column
- `Y_MAX`, 119: last legal row
- `X_START`, 80: x after reset
- `Y_START`, 60: y after reset
- `STEP`, 1: pixels moved per tick per axis, 1..4
- `TIMER_W`, 26: tick timer width
- `TIMER_LIMIT`, 1_000_000: clocks per tick, ≥ 2
- `COLOR_W`, 3: pixel colour width
- `SPRITE_COLOR`, 3'b010: draw colour; erase colour is all-zero
- `CNT_W`, 16: bounce counter width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-low
- `run` in 1: level; 1 lets the tick timer advance
- `obs_x` out X_W: obstacle RAM read x
- `obs_y` out Y_W: obstacle RAM read y
- `obs_color` in COLOR_W: RAM data, valid 1 clk after address; nonzero means blocked
- `px_valid` out 1: pixel write request
- `px_ready` in 1: writer accepts
- `px_x` out X_W, `px_y` out Y_W, `px_color` out COLOR_W: pixel write payload
- `xpos` out X_W, `ypos` out Y_W: sprite position
- `xdir` out 1, `ydir` out 1: 1 = increasing, 0 = decreasing
- `tick` out 1: one-clock pulse on timer expiry
- `bounce_count` out CNT_W: axis flips since reset, wraps
- `busy` out 1: high in every state except WAIT

## Operation
- States: INIT, DRAW, WAIT, ERASE, PROBE_X, PROBE_Y, [PROBE_D], MOVE.
- Transitions:
  - INIT→DRAW: unconditional.
  - DRAW→WAIT: on `px_valid && px_ready`.
  - WAIT→ERASE: on `tick`.
  - ERASE→PROBE_X: on handshake.
  - PROBE_X→PROBE_Y: unconditional.
  - PROBE_Y→MOVE, or PROBE_Y→PROBE_D when the macro is enabled.
  - PROBE_D→MOVE: unconditional.
  - MOVE→DRAW: unconditional.
- DRAW drives `px_*` = (`xpos`, `ypos`, `SPRITE_COLOR`). ERASE drives the same position with colour 0. `px_valid` stays high, and the payload stays stable, until the handshake completes.
- Neighbour targets, where nx = `xpos`±STEP by `xdir` and ny = `ypos`±STEP by `ydir`:
  - PROBE_X presents (nx, `ypos`).
  - PROBE_Y presents (`xpos`, ny) and samples the x result.
  - PROBE_D presents (nx, ny) and samples the y result.
  - MOVE samples the last pending result.
- A neighbour is blocked if `obs_color != 0` or the target lies outside 0..MAX. The bounds test is computed on X_W+1 / Y_W+1 bits, so underflow is detected and never wraps into range.
- MOVE rules:
  - If the x neighbour is blocked, toggle `xdir` and hold `xpos`. Otherwise add or subtract STEP. The y axis follows the same rule independently.
  - Each toggled axis increments `bounce_count` by one, so a corner adds 2.
- Timer:
  - Counts only in WAIT with `run`=1, and holds when `run`=0.
  - Clears on leaving WAIT.
  - `tick` fires when the count equals TIMER_LIMIT-1.
- Outside PROBE states, `obs_x`/`obs_y` hold their last value.

## Timing
- Reset values:
  - Positions: X_START / Y_START. Both dirs: 1.
  - Timer, `bounce_count`, `tick`, `px_valid`: 0.
  - `busy`: 1. State: INIT.
- Reset asserted mid-handshake drops `px_valid` at the next edge. A pending transfer is abandoned and not retried.
- Tick to next draw request, with ready tied high:
  - ERASE 1 clk, PROBE_X 1, PROBE_Y 1, [PROBE_D 1], MOVE 1.
  - DRAW is requested 5 clks after `tick` without the macro, 6 with it.
- `px_ready` may be high before `px_valid`; no combinational path from `px_ready` to `px_valid`.
- `xpos`/`ypos`/dirs change only at the MOVE edge.

## Configuration
- `BOUNCE_DIAG_PROBE_EN` defined:
  - PROBE_D is present.
  - If neither axis neighbour is blocked but the diagonal (nx, ny) is, both dirs toggle, both positions hold, and `bounce_count` increments by 2.
- Undefined:
  - No PROBE_D state.
  - Diagonal-only contacts are not detected, and the sprite may pass through obstacle corners.

## Structure
- `sprite_pkg`:
  - state enum.
  - direction constants DIR_DEC=0, DIR_INC=1.
  - erase colour constant.
- Sub-module `tick_timer`:
  - Parameters TIMER_W and TIMER_LIMIT.
  - Ports `clk`, `reset`, `en`, `clr`, `tick`.
- All other logic lives in `bounce_sprite_engine`.

## Test plan
- Reset, TIMER_LIMIT=4, `run`=1, ready high, empty RAM → first px write (80,60,2). `tick` every 4 WAIT clks; after tick: erase (80,60,0) then draw (81,61,2).
- Sprite at (159,60), xdir=1 → x blocked by border; xdir→0, x holds 159, y→61, `bounce_count`=1.
- Obstacle at (81,59), sprite (80,60), ydir=0, xdir=1 → only... x neighbour (81,60) free, y neighbour (80,59) free; with macro, diagonal blocked: both dirs flip, position holds, count +2. Without macro: sprite moves to (81,59).
- `px_ready` held low 10 clks during DRAW → `px_valid` and payload stable all 10 clks; WAIT entered one clk after ready rises.
- `run`=0 mid-WAIT for 20 clks → timer frozen, no `tick`; resumes counting where it stopped.
- Reset asserted during ERASE with `px_ready`=0 → next clk `px_valid`=0, state INIT, position (80,60).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the bouncing sprite engine.
// Used by bounce_sprite_engine; the optional diagonal probe (BOUNCE_DIAG_PROBE_EN)
// reuses the PROBE_D encoding that is always present in the state type.
package sprite_pkg;

    typedef enum logic [2:0] {
        INIT,
        DRAW,
        WAIT,
        ERASE,
        PROBE_X,
        PROBE_Y,
        PROBE_D,
        MOVE
    } state_t;

    localparam logic DIR_DEC = 1'b0;
    localparam logic DIR_INC = 1'b1;

    // Background colour written when the sprite is removed from its old spot.
    localparam int unsigned ERASE_COLOR = 0;

endpackage

// File: rtl/tick_timer.sv
// Free-running step timer: counts enabled clocks and pulses tick on the last
// count of each period. clr has priority over counting and restarts the period.
module tick_timer #(
    parameter int TIMER_W     = 26,
    parameter int TIMER_LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_LIMIT - 1);

    logic [TIMER_W-1:0] count;

    // Pulse only while counting, so a frozen timer never ticks.
    assign tick = en && (count == LAST);

    // Period counter: cleared outside WAIT, held while disabled, wraps on tick.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Single-pixel sprite mover: draws, waits for a tick, erases, probes the
// obstacle RAM and screen borders around the sprite, then steps or bounces.
// Optional feature macro: BOUNCE_DIAG_PROBE_EN adds a diagonal probe (PROBE_D)
// so corner-only contacts also bounce the sprite.
module bounce_sprite_engine
    import sprite_pkg::*;
#(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int X_START     = 80,
    parameter int Y_START     = 60,
    parameter int STEP        = 1,
    parameter int TIMER_W     = 26,
    parameter int TIMER_LIMIT = 1_000_000,
    parameter int COLOR_W     = 3,
    parameter logic [COLOR_W-1:0] SPRITE_COLOR = 3'b010,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [X_W-1:0]     obs_x,
    output logic [Y_W-1:0]     obs_y,
    input  logic [COLOR_W-1:0] obs_color,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [X_W-1:0]     px_x,
    output logic [Y_W-1:0]     px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic [X_W-1:0]     xpos,
    output logic [Y_W-1:0]     ypos,
    output logic               xdir,
    output logic               ydir,
    output logic               tick,
    output logic [CNT_W-1:0]   bounce_count,
    output logic               busy
);

    // Neighbour arithmetic is one bit wider so an underflow lands above MAX.
    localparam logic [X_W:0]       X_STEP   = (X_W+1)'(STEP);
    localparam logic [Y_W:0]       Y_STEP   = (Y_W+1)'(STEP);
    localparam logic [X_W:0]       X_LIM    = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]       Y_LIM    = (Y_W+1)'(Y_MAX);
    localparam logic [X_W-1:0]     X_RST    = X_W'(X_START);
    localparam logic [Y_W-1:0]     Y_RST    = Y_W'(Y_START);
    localparam logic [COLOR_W-1:0] ERASE_PX = COLOR_W'(ERASE_COLOR);

    state_t           state, next_state;
    logic [X_W:0]     nx_wide;
    logic [Y_W:0]     ny_wide;
    logic [X_W-1:0]   nx;
    logic [Y_W-1:0]   ny;
    logic             nx_oob, ny_oob;
    logic             ram_hit;
    logic             x_blk_q;
    logic             x_flip, y_flip;
    logic [X_W-1:0]   obs_x_q;
    logic [Y_W-1:0]   obs_y_q;
    logic             timer_en, timer_clr;
`ifdef BOUNCE_DIAG_PROBE_EN
    logic             y_blk_q;
`endif

    assign ram_hit   = (obs_color != '0);
    assign timer_en  = (state == WAIT) && run;
    assign timer_clr = (state != WAIT);
    assign px_x      = xpos;
    assign px_y      = ypos;

    tick_timer #(
        .TIMER_W     (TIMER_W),
        .TIMER_LIMIT (TIMER_LIMIT)
    ) u_tick_timer (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (tick)
    );

    // Next position along each axis and whether it falls off the screen.
    always_comb begin
        nx_wide = (xdir == DIR_INC) ? {1'b0, xpos} + X_STEP : {1'b0, xpos} - X_STEP;
        ny_wide = (ydir == DIR_INC) ? {1'b0, ypos} + Y_STEP : {1'b0, ypos} - Y_STEP;
        nx      = nx_wide[X_W-1:0];
        ny      = ny_wide[Y_W-1:0];
        nx_oob  = (nx_wide > X_LIM);
        ny_oob  = (ny_wide > Y_LIM);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus pixel request and probe address outputs.
    always_comb begin
        next_state = state;
        px_valid   = 1'b0;
        px_color   = SPRITE_COLOR;
        busy       = 1'b1;
        obs_x      = obs_x_q;
        obs_y      = obs_y_q;
        case (state)
            INIT: next_state = DRAW;
            DRAW: begin
                px_valid = 1'b1;
                if (px_ready) next_state = WAIT;
            end
            WAIT: begin
                busy = 1'b0;
                if (tick) next_state = ERASE;
            end
            ERASE: begin
                px_valid = 1'b1;
                px_color = ERASE_PX;
                if (px_ready) next_state = PROBE_X;
            end
            PROBE_X: begin
                obs_x      = nx;
                obs_y      = ypos;
                next_state = PROBE_Y;
            end
            PROBE_Y: begin
                obs_x = xpos;
                obs_y = ny;
`ifdef BOUNCE_DIAG_PROBE_EN
                next_state = PROBE_D;
`else
                next_state = MOVE;
`endif
            end
`ifdef BOUNCE_DIAG_PROBE_EN
            PROBE_D: begin
                obs_x      = nx;
                obs_y      = ny;
                next_state = MOVE;
            end
`endif
            MOVE:    next_state = DRAW;
            default: next_state = INIT;
        endcase
    end

    // Bounce decision for MOVE; the RAM result arriving in MOVE is the last probe issued.
    always_comb begin
        x_flip = x_blk_q;
`ifdef BOUNCE_DIAG_PROBE_EN
        y_flip = y_blk_q;
        if (!x_blk_q && !y_blk_q && ram_hit) begin
            x_flip = 1'b1;
            y_flip = 1'b1;
        end
`else
        y_flip = ram_hit || ny_oob;
`endif
    end

    // Probe address hold, probe result capture, and the MOVE-edge position update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xpos         <= X_RST;
            ypos         <= Y_RST;
            xdir         <= DIR_INC;
            ydir         <= DIR_INC;
            bounce_count <= '0;
            x_blk_q      <= 1'b0;
            obs_x_q      <= X_RST;
            obs_y_q      <= Y_RST;
`ifdef BOUNCE_DIAG_PROBE_EN
            y_blk_q      <= 1'b0;
`endif
        end else begin
            obs_x_q <= obs_x;
            obs_y_q <= obs_y;
            if (state == PROBE_Y) begin
                x_blk_q <= ram_hit || nx_oob;
            end
`ifdef BOUNCE_DIAG_PROBE_EN
            if (state == PROBE_D) begin
                y_blk_q <= ram_hit || ny_oob;
            end
`endif
            if (state == MOVE) begin
                if (x_flip) begin
                    xdir <= (xdir == DIR_INC) ? DIR_DEC : DIR_INC;
                end else begin
                    xpos <= nx;
                end
                if (y_flip) begin
                    ydir <= (ydir == DIR_INC) ? DIR_DEC : DIR_INC;
                end else begin
                    ypos <= ny;
                end
                bounce_count <= bounce_count + CNT_W'(x_flip) + CNT_W'(y_flip);
            end
        end
    end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine with a pixel-write scoreboard and a
// synchronous obstacle RAM model. Expectations adapt to BOUNCE_DIAG_PROBE_EN.
module tb_bounce_sprite_engine;

    localparam int XMAX = 159;
    localparam int YMAX = 119;
`ifdef BOUNCE_DIAG_PROBE_EN
    localparam int TICK_TO_DRAW = 6;
`else
    localparam int TICK_TO_DRAW = 5;
`endif

    typedef struct {
        int    x;
        int    y;
        int    c;
        string tag;
    } px_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        px_ready;
    logic [2:0]  obs_color = 3'd0;
    logic [7:0]  obs_x;
    logic [6:0]  obs_y;
    logic        px_valid;
    logic [7:0]  px_x;
    logic [6:0]  px_y;
    logic [2:0]  px_color;
    logic [7:0]  xpos;
    logic [6:0]  ypos;
    logic        xdir;
    logic        ydir;
    logic        tick;
    logic [15:0] bounce_count;
    logic        busy;

    bit  obst [0:255][0:127];
    px_t exp_q [$];
    px_t mon_e;
    int  compared   = 0;
    int  mismatched = 0;
    int  mx, my, mdx, mdy, mcnt;

    always #5 clk = ~clk;

    bounce_sprite_engine #(
        .TIMER_W     (8),
        .TIMER_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .obs_x        (obs_x),
        .obs_y        (obs_y),
        .obs_color    (obs_color),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_color     (px_color),
        .xpos         (xpos),
        .ypos         (ypos),
        .xdir         (xdir),
        .ydir         (ydir),
        .tick         (tick),
        .bounce_count (bounce_count),
        .busy         (busy)
    );

    // Obstacle RAM: data valid one clock after the address.
    always @(posedge clk) begin
        obs_color <= obst[obs_x][obs_y] ? 3'd5 : 3'd0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit blocked_at(input int x, input int y);
        if (x < 0 || x > XMAX || y < 0 || y > YMAX) return 1'b1;
        return obst[x][y];
    endfunction

    task automatic push_exp(input int x, input int y, input int c, input string tag);
        px_t e;
        e.x = x; e.y = y; e.c = c; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Reference movement rules: predicts the erase and draw of one step.
    task automatic model_step(input string tag);
        int nx, ny;
        bit xb, yb, xf, yf;
        nx = (mdx != 0) ? mx + 1 : mx - 1;
        ny = (mdy != 0) ? my + 1 : my - 1;
        xb = blocked_at(nx, my);
        yb = blocked_at(mx, ny);
        xf = xb;
        yf = yb;
`ifdef BOUNCE_DIAG_PROBE_EN
        if (!xb && !yb && blocked_at(nx, ny)) begin
            xf = 1'b1;
            yf = 1'b1;
        end
`endif
        push_exp(mx, my, 0, {tag, "_erase"});
        if (xf) mdx = 1 - mdx; else mx = nx;
        if (yf) mdy = 1 - mdy; else my = ny;
        mcnt = mcnt + int'(xf) + int'(yf);
        push_exp(mx, my, 2, {tag, "_draw"});
    endtask

    task automatic check_model(input string tag);
        check({tag, "_xpos"},   32'(xpos),         mx);
        check({tag, "_ypos"},   32'(ypos),         my);
        check({tag, "_xdir"},   32'(xdir),         mdx);
        check({tag, "_ydir"},   32'(ydir),         mdy);
        check({tag, "_bounce"}, 32'(bounce_count), mcnt & 32'hFFFF);
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic wait_px(input string tag, input logic [2:0] col, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(px_valid === 1'b1 && px_color === col) && n < 60);
        check({tag, "_valid"}, 32'(px_valid), 1);
        check({tag, "_color"}, 32'(px_color), 32'(col));
    endtask

    task automatic step_and_check(input string tag);
        model_step(tag);
        wait_drained(tag);
        check_model(tag);
    endtask

    // Scoreboard: every completed pixel handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && px_valid === 1'b1 && px_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_px", 32'(px_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_x"}, 32'(px_x),     mon_e.x);
                check({mon_e.tag, "_y"}, 32'(px_y),     mon_e.y);
                check({mon_e.tag, "_c"}, 32'(px_color), mon_e.c);
            end
        end
    end

    initial begin
        int  n;
        int  dx, dy;
        bit  xb_done;
        bit  at_edge;
        reset    = 1'b0;
        run      = 1'b1;
        px_ready = 1'b1;
        mx = 80; my = 60; mdx = 1; mdy = 1; mcnt = 0;
        xb_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_px_valid", 32'(px_valid), 0);
        check("rst_busy",     32'(busy),     1);
        check("rst_tick",     32'(tick),     0);
        check_model("rst");

        // First draw after reset
        push_exp(80, 60, 2, "first_draw");
        @(posedge clk); #1 reset = 1'b1;
        wait_px("first", 3'd2, n);

        // Tick period and tick-to-draw latency, first step (81,61)
        model_step("step1");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 50);
        check("tick_period", 32'(n), 4);
        check("tick_in_wait_busy", 32'(busy), 0);
        wait_px("tick_to_draw", 3'd2, n);
        check("tick_to_draw_clks", 32'(n), TICK_TO_DRAW);
        wait_drained("step1");
        check_model("step1");

        // px_ready held low for 10 clocks during DRAW
        model_step("stall");
        wait_px("stall_erase", 3'd0, n);
        @(posedge clk); #1 px_ready = 1'b0;
        wait_px("stall_draw", 3'd2, n);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            check("stall_valid", 32'(px_valid), 1);
            check("stall_x",     32'(px_x),     mx);
            check("stall_y",     32'(px_y),     my);
            check("stall_c",     32'(px_color), 2);
        end
        @(posedge clk); #1 px_ready = 1'b1;
        @(negedge clk);
        check("stall_still_draw", 32'(busy), 1);
        @(negedge clk);
        check("stall_wait_entered", 32'(busy), 0);
        check("stall_drained", 32'(exp_q.size()), 0);

        // run=0 mid-WAIT freezes the timer; resuming continues from count 1
        model_step("freeze");
        @(posedge clk); #1 run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("frozen_tick", 32'(tick), 0);
            check("frozen_wait", 32'(busy), 0);
        end
        @(posedge clk); #1 run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 20);
        check("resume_tick_clks", 32'(n), 3);
        wait_drained("freeze");
        check_model("freeze");

        // Free run until the right border bounces x
        for (int s = 0; s < 120 && !xb_done; s++) begin
            at_edge = (mx == XMAX && mdx == 1);
            step_and_check("run");
            if (at_edge) begin
                xb_done = 1'b1;
                check("xborder_dir", 32'(xdir), 0);
                check("xborder_x",   32'(xpos), XMAX);
            end
        end

        // Obstacle directly ahead on the x axis
        dx = (mdx != 0) ? mx + 1 : mx - 1;
        obst[dx][my] = 1'b1;
        step_and_check("xobst");
        obst[dx][my - ((mdy != 0) ? 1 : -1)] = 1'b0;
        for (int a = 0; a < 160; a++) for (int b = 0; b < 120; b++) obst[a][b] = 1'b0;
        step_and_check("plain");

        // Obstacle only on the diagonal
        dx = (mdx != 0) ? mx + 1 : mx - 1;
        dy = (mdy != 0) ? my + 1 : my - 1;
        obst[dx][dy] = 1'b1;
        step_and_check("diag");
        obst[dx][dy] = 1'b0;

        // Reset while ERASE is stalled
        @(posedge clk); #1 px_ready = 1'b0;
        wait_px("rst_erase", 3'd0, n);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mx = 80; my = 60; mdx = 1; mdy = 1; mcnt = 0;
        check("midrst_px_valid", 32'(px_valid), 0);
        check("midrst_busy",     32'(busy),     1);
        check_model("midrst");
        exp_q.delete();
        px_ready = 1'b1;
        push_exp(80, 60, 2, "post_reset_draw");
        @(posedge clk); #1 reset = 1'b1;
        wait_drained("post_reset");
        check_model("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
